// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and round functions.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_FINAL,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Eight working words, index 0 = a / H0.
  typedef logic [0:7][31:0]  hash_t;
  // Sixteen schedule words, index 0 = oldest.
  typedef logic [0:15][31:0] block_t;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // One compression round on a..h.
  function automatic hash_t sha_round(input hash_t s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = s[7] + big_sigma1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
    t2 = big_sigma0(s[0]) + maj(s[0], s[1], s[2]);
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction

endpackage

// File: rtl/sha256_stream_engine_msg_sched.sv
// 16-word rolling message schedule: words are pushed in during load,
// then each compute cycle emits W[t] and pushes W[t+16].
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        shift_en,
  input  logic        load_sel,
  input  logic [31:0] load_word,
  input  logic        par_en,
  input  block_t      par_block,
  output logic [31:0] w_out
);

  block_t      win_q;
  block_t      win_d;
  logic [31:0] w_next;

  // Next expanded word from the current window W[t..t+15].
  always_comb begin
    w_next = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
  end

  // Window update: parallel load, push of a loaded word, or push of an expanded word.
  always_comb begin
    win_d = win_q;
    if (par_en) begin
      win_d = par_block;
    end else if (shift_en) begin
      win_d = {win_q[1:15], load_sel ? load_word : w_next};
    end
  end

  // NOTE: the window is pure datapath and is fully rewritten before every use, so it carries no reset.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign w_out = win_q[0];

endmodule

// File: rtl/sha256_stream_engine.sv
// Streaming SHA-256 / SHA-256d engine: reads a message from memory block by
// block, pads on the fly and writes the 256-bit digest back.
module sha256_stream_engine
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS    = 1024,
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           double_hash,
  input  logic [$clog2(MAX_WORDS+1)-1:0] num_words,
  input  logic [ADDR_W-1:0]              message_addr,
  input  logic [ADDR_W-1:0]              output_addr,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           mem_clk,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [31:0]                    mem_write_data,
  input  logic [31:0]                    mem_read_data
);

  localparam int          NW_W  = $clog2(MAX_WORDS + 1);
  localparam int          LC_W  = $clog2(16 + READ_LATENCY);
  localparam logic [31:0] MAX_U = 32'(MAX_WORDS);
  localparam logic [31:0] RL_U  = 32'(READ_LATENCY);

  state_t            state_q, state_d;
  logic              dbl_q, dbl_d, second_q, second_d, err_q, err_d;
  logic [NW_W-1:0]   num_q, num_d, blk_q, blk_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d, oaddr_q, oaddr_d;
  logic [LC_W-1:0]   lc_q, lc_d;
  logic [5:0]        rnd_q, rnd_d;
  logic [2:0]        wc_q, wc_d;
  hash_t             h_q, h_d, work_q, work_d, h_sum;

  logic [31:0] num_ext, nb, g_load, g_cap, cap_word, w_sched;
  logic [63:0] len_bits;
  logic        sched_shift, sched_load_sel, sched_par;
  block_t      par_block;

  assign mem_clk   = clk;
  // Second SHA-256d block: previous digest followed by padding for a 256-bit message.
  assign par_block = {h_q, PAD_WORD, 192'h0, 32'h0000_0100};

  // Word index of the read issued and of the word captured this cycle, plus its padded value.
  always_comb begin
    num_ext  = 32'(num_q);
    nb       = (num_ext + 32'd18) >> 4;
    len_bits = 64'(num_q) << 5;
    g_load   = (32'(blk_q) << 4) + 32'(lc_q);
    g_cap    = g_load - RL_U;
    if (g_cap < num_ext) begin
      cap_word = mem_read_data;
    end else if (g_cap == num_ext) begin
      cap_word = PAD_WORD;
    end else if (g_cap == (nb << 4) - 32'd2) begin
      cap_word = len_bits[63:32];
    end else if (g_cap == (nb << 4) - 32'd1) begin
      cap_word = len_bits[31:0];
    end else begin
      cap_word = 32'h0;
    end
  end

  // Intermediate hash plus working variables, added at the end of each block.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_q[i] + work_q[i];
    end
  end

  // Next-state, datapath control and memory interface.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    dbl_d          = dbl_q;
    second_d       = second_q;
    err_d          = err_q;
    num_d          = num_q;
    blk_d          = blk_q;
    maddr_d        = maddr_q;
    oaddr_d        = oaddr_q;
    lc_d           = lc_q;
    rnd_d          = rnd_q;
    wc_d           = wc_q;
    h_d            = h_q;
    work_d         = work_q;
    sched_shift    = 1'b0;
    sched_load_sel = 1'b0;
    sched_par      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    busy           = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dbl_d    = double_hash;
          num_d    = num_words;
          maddr_d  = message_addr;
          oaddr_d  = output_addr;
          h_d      = IV;
          blk_d    = '0;
          lc_d     = '0;
          second_d = 1'b0;
          if (32'(num_words) > MAX_U) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (second_q) begin
          sched_par = 1'b1;
          h_d       = IV;
          work_d    = IV;
          rnd_d     = '0;
          state_d   = ST_COMPUTE;
        end else begin
          if (32'(lc_q) < 32'd16 && g_load < num_ext) begin
            mem_addr = maddr_q + ADDR_W'(g_load);
          end
          if (32'(lc_q) >= RL_U) begin
            sched_shift    = 1'b1;
            sched_load_sel = 1'b1;
          end
          lc_d = lc_q + LC_W'(1);
          if (32'(lc_q) == RL_U + 32'd15) begin
            work_d  = h_q;
            rnd_d   = '0;
            state_d = ST_COMPUTE;
          end
        end
      end
      ST_COMPUTE: begin
        busy        = 1'b1;
        sched_shift = 1'b1;
        work_d      = sha_round(work_q, K[rnd_q], w_sched);
        rnd_d       = rnd_q + 6'd1;
        if (rnd_q == 6'd63) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        busy = 1'b1;
        h_d  = h_sum;
        if (second_q) begin
          wc_d    = '0;
          state_d = ST_WRITE;
        end else if (32'(blk_q) == nb - 32'd1) begin
          if (dbl_q) begin
            second_d = 1'b1;
            state_d  = ST_LOAD;
          end else begin
            wc_d    = '0;
            state_d = ST_WRITE;
          end
        end else begin
          blk_d   = blk_q + NW_W'(1);
          lc_d    = '0;
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        busy           = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = oaddr_q + ADDR_W'(wc_q);
        mem_write_data = h_q[wc_q];
        wc_d           = wc_q + 3'd1;
        if (wc_q == 3'd7) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and hash registers; reset aborts any job immediately.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dbl_q    <= 1'b0;
      second_q <= 1'b0;
      err_q    <= 1'b0;
      num_q    <= '0;
      blk_q    <= '0;
      maddr_q  <= '0;
      oaddr_q  <= '0;
      lc_q     <= '0;
      rnd_q    <= '0;
      wc_q     <= '0;
      h_q      <= '0;
      work_q   <= '0;
    end else begin
      state_q  <= state_d;
      dbl_q    <= dbl_d;
      second_q <= second_d;
      err_q    <= err_d;
      num_q    <= num_d;
      blk_q    <= blk_d;
      maddr_q  <= maddr_d;
      oaddr_q  <= oaddr_d;
      lc_q     <= lc_d;
      rnd_q    <= rnd_d;
      wc_q     <= wc_d;
      h_q      <= h_d;
      work_q   <= work_d;
    end
  end

  sha256_msg_sched u_sched (
    .clk       (clk),
    .shift_en  (sched_shift),
    .load_sel  (sched_load_sel),
    .load_word (cap_word),
    .par_en    (sched_par),
    .par_block (par_block),
    .w_out     (w_sched)
  );

endmodule

// File: doc/sha256_stream_engine.md
Name: sha256_stream_engine

Overview:
Parametrised successor to the team's single-message SHA-256 memory engine. Reads a message of runtime-selectable word length from shared memory and pads it on the fly, block by block, so no full-message buffer is needed. Writes the 256-bit digest back to memory. Adds a double-hash mode (SHA-256d, for mining), configurable memory read latency, a busy/done handshake and error reporting.

Parameters:
MAX_WORDS, 1024, largest accepted message length in 32-bit words
ADDR_W, 16, memory address width
READ_LATENCY, 1, cycles from mem_addr issue to valid mem_read_data (1..4)

Ports:
clk  in  1  single clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
double_hash  in  1  1 = SHA-256d; sampled with start
num_words  in  $clog2(MAX_WORDS+1)  message length in words; sampled with start
message_addr  in  ADDR_W  word address of message word 0
output_addr  in  ADDR_W  word address for digest word H0
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at end of job
err  out  1  valid with done; 1 = num_words > MAX_WORDS
mem_clk  out  1  equal to clk
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  memory word address
mem_write_data  out  32  write data
mem_read_data  in  32  read data

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_write_data=0. Reset mid-job aborts at once; no further writes.
- Accept: start=1 in IDLE latches double_hash, num_words and both addresses; H0..H7 load the FIPS 180-4 IV. start while busy is ignored.
- Error: num_words > MAX_WORDS → next cycle done=1, err=1, no memory access.
- Block count nb = ceil((num_words+3)/16). Bit length L = num_words*32, as 64-bit big-endian.
- Global word index g = 16*blk + t. Source of word g:
  - g < num_words: memory word at message_addr+g
  - g == num_words: 0x80000000
  - g == 16*nb-2: L[63:32]
  - g == 16*nb-1: L[31:0]
  - all other g: 0x00000000
- LOAD state, per block:
  - issue reads only for g < num_words, one per cycle;
  - capture data READ_LATENCY cycles later into W[0..15];
  - lasts 16+READ_LATENCY cycles, fixed, regardless of padding.
- COMPUTE state:
  - 64 rounds, one per cycle;
  - W[16..63] expanded on the fly in a 16-entry rolling window (sigma0/sigma1 per FIPS);
  - working registers a..h start from H.
- FINAL state: 1 cycle, H += a..h (mod 2^32). Then the next block goes to LOAD, or the job continues.
- Double mode: after the last block, one more block is formed from the digest with no memory reads:
  - W[0..7] = H0..H7, W[8] = 0x80000000, W[9..14] = 0, W[15] = 0x00000100;
  - H re-loads the IV first;
  - LOAD for this block takes 1 cycle.
- WRITE state: 8 cycles, mem_we=1, mem_addr=output_addr+k, data=Hk for k=0..7. Next cycle: mem_we=0, done=1, busy=0, state IDLE.
- Addresses wrap modulo 2^ADDR_W.
- Latency (single mode) = 1 + nb*(81+READ_LATENCY) + 8 cycles from start to done.
- States: IDLE, LOAD, COMPUTE, FINAL, WRITE, DONE.

Decomposition:
- Package sha256_pkg:
  - K[0:63], IV[0:7]
  - state enum
  - functions rotr, Sigma0/1, sigma0/1, ch, maj, round
- Sub-module sha256_msg_sched: 16-word rolling window; load port and per-cycle W output.

Test Plan:
- num_words=0, READ_LATENCY=1 → digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at output_addr..+7; done exactly 91 cycles after start; err=0.
- num_words=1, word 0x00000000 → df3f6198 04a92fdb 4057192d c43dd748 ea778adc 52bc498c e80524c0 14b81119.
- num_words=0, double_hash=1 → 5df6e0e2 761359d3 0a827505 8e299fcc 03815345 45f55cf4 3e41983f 5d4c9456.
- Padding boundary: num_words=13 (1 block) and 14 (2 blocks) with random data, READ_LATENCY=3; check against golden model. Also num_words=20 (2 blocks) and MAX_WORDS.
- num_words=MAX_WORDS+1 → done and err pulse together 1 cycle after start; mem_we stays 0.
- Reset mid-COMPUTE, plus start pulses while busy → immediate idle outputs; no writes; the next job gives the correct digest.
